// File: rtl/rect_fill_writer.sv
// Raster-order rectangle fill engine driving a one-pixel-per-cycle bitmap write port.
// Optional macro RECT_CLIP_EN suppresses writes to pixels outside SCREEN_W x SCREEN_H.
module rect_fill_writer #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] x0,
  input  logic [7:0] y0,
  input  logic [8:0] width,
  input  logic [7:0] height,
  input  logic [2:0] color_in,
  output logic       busy,
  output logic       done,
  output logic [8:0] x,
  output logic [7:0] y,
  output logic [2:0] color,
  output logic       wr_en
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t     state;
  logic [8:0] xs;
  logic [9:0] cx;
  logic [9:0] x_end;
  logic [8:0] cy;
  logic [8:0] y_end;

  logic       row_end;
  logic       last;
  logic [9:0] nx;
  logic [8:0] ny;
  logic       start_vis;
  logic       next_vis;
  logic       empty;

  always_comb begin
    row_end = (cx + 10'd1) == x_end;
    last    = row_end && ((cy + 9'd1) == y_end);
    nx      = row_end ? {1'b0, xs} : cx + 10'd1;
    ny      = row_end ? cy + 9'd1 : cy;
    empty   = (width == 9'd0) || (height == 8'd0);
  end

`ifdef RECT_CLIP_EN
  localparam logic [9:0] XLIM = 10'(SCREEN_W);
  localparam logic [8:0] YLIM = 9'(SCREEN_H);

  assign start_vis = ({1'b0, x0} < XLIM) && ({1'b0, y0} < YLIM);
  assign next_vis  = (nx < XLIM) && (ny < YLIM);
`else
  assign start_vis = 1'b1;
  assign next_vis  = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      wr_en <= 1'b0;
      x     <= '0;
      y     <= '0;
      color <= '0;
      xs    <= '0;
      cx    <= '0;
      cy    <= '0;
      x_end <= '0;
      y_end <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          wr_en <= 1'b0;
          if (start) begin
            busy  <= 1'b1;
            xs    <= x0;
            cx    <= {1'b0, x0};
            cy    <= {1'b0, y0};
            x_end <= {1'b0, x0} + {1'b0, width};
            y_end <= {1'b0, y0} + {1'b0, height};
            if (empty) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= DRAW;
              x     <= x0;
              y     <= y0;
              color <= color_in;
              wr_en <= start_vis;
            end
          end
        end
        DRAW: begin
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
            wr_en <= 1'b0;
          end else begin
            cx    <= nx;
            cy    <= ny;
            x     <= nx[8:0];
            y     <= ny[7:0];
            wr_en <= next_vis;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_writer.sv
// Directed table-driven bench for rect_fill_writer (default and RECT_CLIP_EN builds).
module tb_rect_fill_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [8:0] x0;
  logic [7:0] y0;
  logic [8:0] width;
  logic [7:0] height;
  logic [2:0] color_in;
  logic       busy;
  logic       done;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] color;
  logic       wr_en;

  int total = 0;
  int passed = 0;

  rect_fill_writer dut (
    .clk(clk), .reset(reset), .start(start),
    .x0(x0), .y0(y0), .width(width), .height(height),
    .color_in(color_in), .busy(busy), .done(done),
    .x(x), .y(y), .color(color), .wr_en(wr_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x0, y0, w, h, col;
    int restart;
    int n, fx, fy, lx, ly, span, done_k;
  } vec_t;

  vec_t vecs[$];

  // record of the most recent fill
  int wx[$];
  int wy[$];
  int n_w, f_k, l_k, done_k, bad_col, busy_lo;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // entered and left on a negedge; left in the idle cycle after DONE
  task automatic run_fill(input int ax0, ay0, aw, ah, acol, restart);
    int k;
    wx.delete(); wy.delete();
    n_w = 0; f_k = 0; l_k = 0; done_k = 0; bad_col = 0; busy_lo = 0;
    x0 = 9'(ax0); y0 = 8'(ay0); width = 9'(aw);
    height = 8'(ah); color_in = 3'(acol);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x0 = 9'd100; y0 = 8'd100; width = 9'd7; color_in = 3'd0;
    k = 1;
    while (k < 3000) begin
      if (restart != 0 && k == 2) start = 1'b1;
      if (restart != 0 && k == 3) start = 1'b0;
      if (!busy) busy_lo++;
      if (wr_en) begin
        if (n_w == 0) f_k = k;
        l_k = k;
        n_w++;
        wx.push_back(int'(x));
        wy.push_back(int'(y));
        if (color != 3'(acol)) bad_col++;
      end
      if (done) begin
        done_k = k;
        break;
      end
      @(negedge clk);
      k++;
    end
    if (done_k == 0) $display("FAIL timeout: done never seen");
    chk("timeout", done_k == 0 ? 1 : 0, 0);
    @(negedge clk);
    chk("done_width", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0;
    x0 = '0; y0 = '0; width = '0; height = '0; color_in = '0;
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wr", int'(wr_en), 0);
    chk("rst_xyc", int'({x, y, color}), 0);

    //             x0  y0  w h col rs  n  fx  fy  lx  ly sp dk
    vecs.push_back('{10, 20, 3, 2, 5, 0, 6, 10, 20, 12, 21, 6, 7});
    vecs.push_back('{7, 9, 0, 5, 6, 0, 0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{7, 9, 4, 0, 6, 0, 0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{1, 1, 1, 1, 7, 0, 1, 1, 1, 1, 1, 1, 2});
    vecs.push_back('{5, 6, 4, 3, 1, 1, 12, 5, 6, 8, 8, 12, 13});
    vecs.push_back('{300, 200, 1, 3, 2, 0, 3, 300, 200, 300, 202, 3, 4});
`ifdef RECT_CLIP_EN
    vecs.push_back('{318, 239, 4, 2, 4, 0, 2, 318, 239, 319, 239, 2, 9});
`else
    vecs.push_back('{510, 0, 4, 1, 3, 0, 4, 510, 0, 1, 0, 4, 5});
    vecs.push_back('{0, 254, 2, 3, 2, 0, 6, 0, 254, 1, 0, 6, 7});
`endif

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      run_fill(v.x0, v.y0, v.w, v.h, v.col, v.restart);
      chk($sformatf("v%0d_n", i), n_w, v.n);
      chk($sformatf("v%0d_done_k", i), done_k, v.done_k);
      chk($sformatf("v%0d_busy", i), busy_lo, 0);
      chk($sformatf("v%0d_col", i), bad_col, 0);
      if (v.n > 0) begin
        chk($sformatf("v%0d_fx", i), wx[0], v.fx);
        chk($sformatf("v%0d_fy", i), wy[0], v.fy);
        chk($sformatf("v%0d_lx", i), wx[n_w-1], v.lx);
        chk($sformatf("v%0d_ly", i), wy[n_w-1], v.ly);
        chk($sformatf("v%0d_first_k", i), f_k, 1);
        chk($sformatf("v%0d_span", i), l_k - f_k + 1, v.span);
      end
    end

    // exact raster sequence for the reference rectangle
    begin
      int ex[6] = '{10, 11, 12, 10, 11, 12};
      int ey[6] = '{20, 20, 20, 21, 21, 21};
      run_fill(10, 20, 3, 2, 5, 0);
      chk("seq_n", n_w, 6);
      for (int j = 0; j < 6 && j < n_w; j++) begin
        chk($sformatf("seq_x%0d", j), wx[j], ex[j]);
        chk($sformatf("seq_y%0d", j), wy[j], ey[j]);
      end
    end

`ifndef RECT_CLIP_EN
    begin
      int ex[4] = '{510, 511, 0, 1};
      run_fill(510, 0, 4, 1, 3, 0);
      for (int j = 0; j < 4 && j < n_w; j++)
        chk($sformatf("wrap_x%0d", j), wx[j], ex[j]);
    end
`endif

    // asynchronous reset in the middle of DRAW, away from any clock edge
    begin
      int stray;
      x0 = 9'd40; y0 = 8'd50; width = 9'd5; height = 8'd4; color_in = 3'd6;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_wr", int'(wr_en), 1);
      #2 reset = 1'b0;
      #1;
      chk("arst_wr", int'(wr_en), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_x", int'(x), 0);
      chk("arst_y", int'(y), 0);
      chk("arst_color", int'(color), 0);
      @(negedge clk);
      reset = 1'b1;
      stray = 0;
      for (int j = 0; j < 30; j++) begin
        @(negedge clk);
        if (wr_en || busy) stray++;
      end
      chk("post_rst_quiet", stray, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
